// File: rtl/sd_req_arbiter_if.sv
// Client-side and SD-wrapper-side signals of the sector request arbiter.
// master = arbiter view, slave = clients plus wrapper (the environment).
interface sd_req_arbiter_if #(
   parameter int NCLIENT = 4
);
   logic [NCLIENT-1:0]    cl_rd;
   logic [NCLIENT-1:0]    cl_wr;
   logic [32*NCLIENT-1:0] cl_sector;
   logic [8*NCLIENT-1:0]  cl_inbyte;
   logic [NCLIENT-1:0]    cl_done;
   logic [NCLIENT-1:0]    cl_busy;
   logic [NCLIENT-1:0]    cl_outen;
   logic [8:0]            cl_addr;
   logic [7:0]            cl_outbyte;
   logic [7:0]            rstart;
   logic [7:0]            wstart;
   logic [31:0]           rsector;
   logic                  rdone;
   logic [7:0]            inbyte;
   logic                  outen;
   logic [8:0]            outaddr;
   logic [7:0]            outbyte;

   modport master (
      input  cl_rd, cl_wr, cl_sector, cl_inbyte, rdone, outen, outaddr, outbyte,
      output cl_done, cl_busy, cl_outen, cl_addr, cl_outbyte,
             rstart, wstart, rsector, inbyte
   );

   modport slave (
      output cl_rd, cl_wr, cl_sector, cl_inbyte, rdone, outen, outaddr, outbyte,
      input  cl_done, cl_busy, cl_outen, cl_addr, cl_outbyte,
             rstart, wstart, rsector, inbyte
   );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter of up to 8 sector clients onto one SD wrapper command port.
// Grant registers one cycle after a request; each request is held until rdone, then a forced idle gap.
module sd_req_arbiter #(
   parameter int NCLIENT    = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rstn,
   sd_req_arbiter_if.master   bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_GAP    = 2'd2;

   logic [1:0]         state;
   logic [2:0]         rr_ptr;
   logic [2:0]         gnt;
   logic [3:0]         gap_cnt;
   logic [7:0]         rstart_q;
   logic [7:0]         wstart_q;
   logic [31:0]        rsector_q;
   logic [NCLIENT-1:0] busy_q;
   logic [NCLIENT-1:0] done_q;

   logic [31:0] sec_arr [8];
   logic [7:0]  in_arr  [8];

   // Pad per-client buses out to 8 entries so grant indices never select past NCLIENT.
   for (genvar g = 0; g < 8; g++) begin : g_pad
      if (g < NCLIENT) begin : g_real
         assign sec_arr[g] = bus.cl_sector[32*g +: 32];
         assign in_arr[g]  = bus.cl_inbyte[8*g +: 8];
      end else begin : g_none
         assign sec_arr[g] = 32'h0;
         assign in_arr[g]  = 8'h0;
      end
   end

   logic [7:0] pend8;
   logic [7:0] rd8;
   logic [7:0] pick_oh;
   logic [7:0] gnt_oh;
   logic [2:0] pick;
   logic [2:0] cand;
   logic [3:0] sum;
   logic       found;
   logic [3:0] nxt;
   logic [2:0] rr_next;

   assign pend8   = 8'(bus.cl_rd | bus.cl_wr);
   assign rd8     = 8'(bus.cl_rd);
   assign pick_oh = 8'd1 << pick;
   assign gnt_oh  = 8'd1 << gnt;
   assign nxt     = {1'b0, gnt} + 4'd1;
   assign rr_next = (nxt >= 4'(NCLIENT)) ? 3'd0 : nxt[2:0];

   // First pending client at or after rr_ptr, wrapping inside 0..NCLIENT-1.
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      sum   = 4'd0;
      cand  = 3'd0;
      for (int i = 0; i < NCLIENT; i++) begin
         sum = {1'b0, rr_ptr} + 4'(i);
         if (sum >= 4'(NCLIENT)) sum = sum - 4'(NCLIENT);
         cand = sum[2:0];
         if (!found && pend8[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= S_IDLE;
         rr_ptr    <= 3'd0;
         gnt       <= 3'd0;
         gap_cnt   <= 4'd0;
         rstart_q  <= 8'h0;
         wstart_q  <= 8'h0;
         rsector_q <= 32'h0;
         busy_q    <= '0;
         done_q    <= '0;
      end else begin
         done_q <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  gnt       <= pick;
                  rsector_q <= sec_arr[pick];
                  busy_q    <= pick_oh[NCLIENT-1:0];
                  if (rd8[pick]) rstart_q <= pick_oh;
                  else           wstart_q <= pick_oh;
                  state     <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (bus.rdone) begin
                  rstart_q <= 8'h0;
                  wstart_q <= 8'h0;
                  busy_q   <= '0;
                  done_q   <= gnt_oh[NCLIENT-1:0];
                  rr_ptr   <= rr_next;
                  gap_cnt  <= 4'(GAP_CYCLES - 1);
                  state    <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == 4'd0) state <= S_IDLE;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.rstart     = rstart_q;
   assign bus.wstart     = wstart_q;
   assign bus.rsector    = rsector_q;
   assign bus.cl_busy    = busy_q;
   assign bus.cl_done    = done_q;
   assign bus.cl_addr    = bus.outaddr;
   assign bus.cl_outbyte = bus.outbyte;
   // Write data goes straight through so the wrapper gets the byte for outaddr in the same cycle.
   assign bus.cl_outen   = (state == S_ACTIVE && bus.outen) ? gnt_oh[NCLIENT-1:0] : '0;
   assign bus.inbyte     = (state == S_ACTIVE) ? in_arr[gnt] : 8'h00;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: reads, write mux, round-robin order, ties, reset and stray events.
`timescale 1ns/1ps
module tb_sd_req_arbiter;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sd_req_arbiter_if #(.NCLIENT(4)) bus ();

   sd_req_arbiter #(.NCLIENT(4), .GAP_CYCLES(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.master)
   );

   // Client write data: client 2 returns ~addr, the others fixed bytes.
   always_comb bus.cl_inbyte = {8'hC3, ~bus.cl_addr[7:0], 8'h5A, 8'hA5};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse rdone, check the done pulse and that the start lines stay low through the gap.
   task automatic do_done(input logic [3:0] exp_done, input logic [3:0] rd_after,
                          input logic [3:0] wr_after);
      bus.rdone = 1'b1;
      step(1);
      bus.rdone = 1'b0;
      chk("done_pulse", 64'(bus.cl_done), 64'(exp_done));
      chk("done_busy_clr", 64'(bus.cl_busy), 64'h0);
      chk("gap1_starts", 64'({bus.rstart, bus.wstart}), 64'h0);
      bus.cl_rd = rd_after;
      bus.cl_wr = wr_after;
      step(1);
      chk("done_one_cycle", 64'(bus.cl_done), 64'h0);
      chk("gap2_starts", 64'({bus.rstart, bus.wstart}), 64'h0);
      step(1);
      chk("gap3_starts", 64'({bus.rstart, bus.wstart}), 64'h0);
   endtask

   initial begin
      logic [8:0] addr;
      bus.cl_rd     = '0;
      bus.cl_wr     = '0;
      bus.cl_sector = {32'h3333_0003, 32'hDEAD_0002, 32'h0000_1234, 32'h0000_00F0};
      bus.rdone     = 1'b0;
      bus.outen     = 1'b0;
      bus.outaddr   = 9'd0;
      bus.outbyte   = 8'd0;

      // Reset state
      step(2);
      chk("rst_rstart", 64'(bus.rstart), 64'h0);
      chk("rst_wstart", 64'(bus.wstart), 64'h0);
      chk("rst_rsector", 64'(bus.rsector), 64'h0);
      chk("rst_busy_done", 64'({bus.cl_busy, bus.cl_done, bus.cl_outen}), 64'h0);
      chk("rst_inbyte", 64'(bus.inbyte), 64'h0);
      rstn = 1'b1;
      step(1);

      // Single read from client 1
      bus.cl_rd = 4'b0010;
      step(1);
      chk("rd_rstart", 64'(bus.rstart), 64'h02);
      chk("rd_wstart", 64'(bus.wstart), 64'h00);
      chk("rd_rsector", 64'(bus.rsector), 64'h0000_1234);
      chk("rd_busy", 64'(bus.cl_busy), 64'b0010);
      for (int a = 0; a < 512; a++) begin
         addr        = 9'(a);
         bus.outen   = 1'b1;
         bus.outaddr = addr;
         bus.outbyte = addr[7:0];
         #1;
         chk("rd_strobe", 64'({bus.cl_outen, bus.cl_addr, bus.cl_outbyte}),
             64'({4'b0010, addr, addr[7:0]}));
         step(1);
      end
      bus.outen = 1'b0;
      #1;
      chk("rd_outen_off", 64'(bus.cl_outen), 64'h0);
      chk("rd_hold", 64'({bus.rstart, bus.rsector}), 64'({8'h02, 32'h0000_1234}));
      do_done(4'b0010, 4'b0000, 4'b0000);

      // Write from client 2, data muxed combinationally
      bus.cl_wr = 4'b0100;
      step(1);
      chk("wr_wstart", 64'(bus.wstart), 64'h04);
      chk("wr_rstart", 64'(bus.rstart), 64'h00);
      chk("wr_rsector", 64'(bus.rsector), 64'hDEAD_0002);
      bus.outaddr = 9'd5;
      #1;
      chk("wr_inbyte5", 64'(bus.inbyte), 64'hFA);
      bus.outaddr = 9'h10A;
      #1;
      chk("wr_inbyte10a", 64'(bus.inbyte), 64'hF5);
      step(2);
      do_done(4'b0100, 4'b0000, 4'b0000);

      // Read/write tie on client 0, read dropped early
      bus.cl_rd = 4'b0001;
      bus.cl_wr = 4'b0001;
      step(1);
      chk("tie_starts", 64'({bus.rstart, bus.wstart}), 64'h0100);
      chk("tie_rsector", 64'(bus.rsector), 64'h0000_00F0);
      bus.cl_rd = 4'b0000;
      step(3);
      chk("drop_hold", 64'({bus.rstart, bus.wstart, bus.cl_busy}), 64'({8'h01, 8'h00, 4'b0001}));
      do_done(4'b0001, 4'b0000, 4'b0000);

      // Reset mid-transfer: rr_ptr is 1 here, client 2 gets the grant
      bus.cl_rd = 4'b0100;
      step(1);
      chk("pre_rst_grant", 64'(bus.rstart), 64'h04);
      bus.outen = 1'b1;
      step(1);
      bus.cl_rd = 4'b1011;
      rstn      = 1'b0;
      step(1);
      chk("mid_rst_starts", 64'({bus.rstart, bus.wstart}), 64'h0);
      chk("mid_rst_rsector", 64'(bus.rsector), 64'h0);
      chk("mid_rst_cl", 64'({bus.cl_busy, bus.cl_done, bus.cl_outen}), 64'h0);
      chk("mid_rst_inbyte", 64'(bus.inbyte), 64'h0);
      rstn      = 1'b1;
      bus.outen = 1'b0;
      step(1);

      // Round-robin with 1011 held: 0,1,3,0
      chk("rr_grant0", 64'({bus.rstart, bus.cl_busy, bus.cl_done}), 64'({8'h01, 4'b0001, 4'b0000}));
      step(2);
      do_done(4'b0001, 4'b1011, 4'b0000);
      step(1);
      chk("rr_grant1", 64'({bus.rstart, bus.rsector}), 64'({8'h02, 32'h0000_1234}));
      step(1);
      do_done(4'b0010, 4'b1011, 4'b0000);
      step(1);
      chk("rr_grant3", 64'({bus.rstart, bus.rsector}), 64'({8'h08, 32'h3333_0003}));
      step(1);
      do_done(4'b1000, 4'b1011, 4'b0000);
      step(1);
      chk("rr_grant0b", 64'({bus.rstart, bus.rsector}), 64'({8'h01, 32'h0000_00F0}));
      step(1);
      do_done(4'b0001, 4'b0000, 4'b0000);

      // Stray rdone/outen while idle
      bus.rdone   = 1'b1;
      bus.outen   = 1'b1;
      bus.outaddr = 9'd3;
      #1;
      chk("stray_outen", 64'(bus.cl_outen), 64'h0);
      step(1);
      chk("stray_done", 64'({bus.cl_done, bus.cl_busy, bus.cl_outen}), 64'h0);
      chk("stray_starts", 64'({bus.rstart, bus.wstart}), 64'h0);
      bus.rdone = 1'b0;
      bus.outen = 1'b0;
      step(1);
      chk("stray_done2", 64'(bus.cl_done), 64'h0);
      bus.cl_wr = 4'b1000;
      step(1);
      chk("post_stray_grant", 64'({bus.rstart, bus.wstart}), 64'h0008);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
